// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter: register names, default
// widths and the aux queue entry layout.
package wb_port_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;
  localparam logic [AW_DEF-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } q_ent_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the W stage / aux producer / D stage and the write-port
// arbiter. Forward ports exist only when WB_ARB_FWD_EN is defined.
interface wb_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          aux_valid;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_data;
  logic          aux_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          hazard_stall;
`ifdef WB_ARB_FWD_EN
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;
`endif

  // Arbiter side
  modport slave (
    input  wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data, rd_addr1, rd_addr2,
    output aux_ready, rf_we, rf_addr, rf_data, hazard_stall
`ifdef WB_ARB_FWD_EN
    , output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
`endif
  );

  // Pipeline / producer side
  modport master (
    output wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data, rd_addr1, rd_addr2,
    input  aux_ready, rf_we, rf_addr, rf_data, hazard_stall
`ifdef WB_ARB_FWD_EN
    , input fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
`endif
  );

endinterface

// File: rtl/wb_port_arbiter_queue.sv
// wb_arb_queue: age-ordered aux write queue (slot 0 = oldest) with push, pop,
// per-address kill, compaction and per-entry read-address match vectors.
module wb_arb_queue
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [AW-1:0]             kill_addr,
  input  logic [AW-1:0]             rd_addr1,
  input  logic [AW-1:0]             rd_addr2,
  output logic [CW-1:0]             count,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data,
  output logic [DEPTH-1:0]          match1,
  output logic [DEPTH-1:0]          match2
`ifdef WB_ARB_FWD_EN
  , output logic [DEPTH-1:0][DW-1:0] ent_data
`endif
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t [DEPTH-1:0] q, q_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Survivors slide down in age order, then the new entry lands behind them.
  always_comb begin
    int n;
    q_nxt = '0;
    n     = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && !(pop && i == 0) && !(kill && q[i].addr == kill_addr)) begin
        q_nxt[n] = q[i];
        n++;
      end
    end
    if (push && n < DEPTH) begin
      q_nxt[n] = '{valid: 1'b1, addr: push_addr, data: push_data};
      n++;
    end
    cnt_nxt = CW'(n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= cnt_nxt;
    end
  end

  assign head_addr = q[0].addr;
  assign head_data = q[0].data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic live;
    assign live      = q[i].valid && (q[i].addr != AW'(REG_ZERO));
    assign match1[i] = live && (q[i].addr == rd_addr1);
    assign match2[i] = live && (q[i].addr == rd_addr2);
`ifdef WB_ARB_FWD_EN
    assign ent_data[i] = q[i].data;
`endif
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// GRF write-port arbiter: W-stage writes win, aux writes bypass when the port is
// free or wait in wb_arb_queue. Define WB_ARB_FWD_EN to forward queued data instead of stalling.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  wb_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [DEPTH-1:0] match1, match2;
  logic             wb_live, aux_live, aux_acc, q_empty;
  logic             pop, bypass, push;
`ifdef WB_ARB_FWD_EN
  logic [DEPTH-1:0][DW-1:0] ent_data;
`endif

  assign wb_live  = bus.wb_we && (bus.wb_addr != AW'(REG_ZERO));
  assign aux_live = bus.aux_addr != AW'(REG_ZERO);
  assign q_empty  = (count == '0);

  assign bus.aux_ready = !reset && (count != CW'(DEPTH));
  assign aux_acc       = bus.aux_valid && bus.aux_ready;

  assign pop    = !wb_live && !q_empty;
  assign bypass = !wb_live && q_empty && aux_acc && aux_live;
  // An aux result is older than a same-cycle W write to the same register, so it is dropped.
  assign push   = aux_acc && aux_live && !bypass && !(wb_live && bus.aux_addr == bus.wb_addr);

  wb_arb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.aux_addr),
    .push_data (bus.aux_data),
    .pop       (pop),
    .kill      (wb_live),
    .kill_addr (bus.wb_addr),
    .rd_addr1  (bus.rd_addr1),
    .rd_addr2  (bus.rd_addr2),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .match1    (match1),
    .match2    (match2)
`ifdef WB_ARB_FWD_EN
    , .ent_data (ent_data)
`endif
  );

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = '0;
    bus.rf_data = '0;
    if (!reset) begin
      if (wb_live) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.wb_addr;
        bus.rf_data = bus.wb_data;
      end else if (!q_empty) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = head_addr;
        bus.rf_data = head_data;
      end else if (bypass) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.aux_addr;
        bus.rf_data = bus.aux_data;
      end
    end
  end

`ifdef WB_ARB_FWD_EN
  // Higher slot index is younger, so the last match wins.
  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match1[i]) begin
        bus.fwd1_hit  = 1'b1;
        bus.fwd1_data = ent_data[i];
      end
      if (match2[i]) begin
        bus.fwd2_hit  = 1'b1;
        bus.fwd2_data = ent_data[i];
      end
    end
  end
  assign bus.hazard_stall = 1'b0;
`else
  assign bus.hazard_stall = !reset && |(match1 | match2);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.AW(5), .DW(32)) bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t mq[$];
  int checks = 0;
  int errors = 0;

  logic        o_we, o_rdy, o_hz;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
`ifdef WB_ARB_FWD_EN
  logic        o_h1, o_h2;
  logic [31:0] o_d1, o_d2;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.aux_valid = av;
    bus.aux_addr  = aa;
    bus.aux_data  = ad;
  endtask

  // Compare outputs against the model, then advance the model across the edge.
  task automatic step();
    logic        wbw, acc, byp, e_rdy, e_we, e_hz;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    ment_t       nq[$];
`ifdef WB_ARB_FWD_EN
    logic        e_h1, e_h2;
    logic [31:0] e_d1, e_d2;
`endif
    #1;
    wbw   = bus.wb_we && bus.wb_addr != 5'd0;
    e_rdy = !reset && mq.size() < DEPTH;
    acc   = bus.aux_valid && e_rdy;
    e_we = 1'b0; e_a = '0; e_d = '0; byp = 1'b0; e_hz = 1'b0;
    if (!reset) begin
      if (wbw) begin
        e_we = 1'b1; e_a = bus.wb_addr; e_d = bus.wb_data;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
      end else if (acc && bus.aux_addr != 5'd0) begin
        e_we = 1'b1; e_a = bus.aux_addr; e_d = bus.aux_data; byp = 1'b1;
      end
      foreach (mq[i])
        if (mq[i].a == bus.rd_addr1 || mq[i].a == bus.rd_addr2) e_hz = 1'b1;
    end
`ifdef WB_ARB_FWD_EN
    e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
    foreach (mq[i]) begin
      if (mq[i].a == bus.rd_addr1) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (mq[i].a == bus.rd_addr2) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
    e_hz = 1'b0;
    o_h1 = bus.fwd1_hit; o_h2 = bus.fwd2_hit; o_d1 = bus.fwd1_data; o_d2 = bus.fwd2_data;
    if (!reset) begin
      chk("fwd1_hit", o_h1, e_h1);
      chk("fwd2_hit", o_h2, e_h2);
      if (e_h1) chk("fwd1_data", o_d1, e_d1);
      if (e_h2) chk("fwd2_data", o_d2, e_d2);
    end
`endif
    o_we = bus.rf_we; o_rdy = bus.aux_ready; o_hz = bus.hazard_stall;
    o_addr = bus.rf_addr; o_data = bus.rf_data;
    chk("aux_ready", o_rdy, e_rdy);
    chk("rf_we", o_we, e_we);
    if (e_we) begin
      chk("rf_addr", o_addr, e_a);
      chk("rf_data", o_data, e_d);
    end
    chk("hazard_stall", o_hz, e_hz);
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      foreach (mq[i])
        if (!(wbw && mq[i].a == bus.wb_addr)) nq.push_back(mq[i]);
      if (!wbw && nq.size() > 0) void'(nq.pop_front());
      if (acc && bus.aux_addr != 5'd0 && !byp && !(wbw && bus.aux_addr == bus.wb_addr))
        nq.push_back('{a: bus.aux_addr, d: bus.aux_data});
      mq = nq;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    @(negedge clk);

    // 1: reset blocks both sources
    step();
    chk("t1_rst_rf_we", o_we, 1'b0);
    chk("t1_rst_ready", o_rdy, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("t1_ready_after", o_rdy, 1'b1);
    chk("t1_rf_we_after", o_we, 1'b0);

    // 2: bypass on a free port
    bus.rd_addr1 = 5'd8;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
    step();
    chk("t2_we", o_we, 1'b1);
    chk("t2_addr", o_addr, 5'd8);
    chk("t2_data", o_data, 32'h1234);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("t2_no_drain", o_we, 1'b0);
    chk("t2_no_hazard", o_hz, 1'b0);
    bus.rd_addr1 = 5'd0;

    // 3: three W cycles with aux $10,$11,$12 behind them
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h10); step();
    chk("t3_c1_addr", o_addr, 5'd9);
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'h11); step();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'h12); step();
    chk("t3_full_ready", o_rdy, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h12); step();
    chk("t3_drain10", o_addr, 5'd10);
    chk("t3_held_ready", o_rdy, 1'b0);
    step();
    chk("t3_drain11", o_addr, 5'd11);
    chk("t3_accept12", o_rdy, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); step();
    chk("t3_drain12", o_addr, 5'd12);
    chk("t3_data12", o_data, 32'h12);
    step();
    chk("t3_empty", o_we, 1'b0);

    // 4: queued $10 killed by a younger W write
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd10, 32'hBBBB); step();
    drive(1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 32'h0); step();
    chk("t4_w_data", o_data, 32'hAAAA);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); step();
    chk("t4_no_stale", o_we, 1'b0);

    // 5: hazard / forward on a queued $5
    bus.rd_addr1 = 5'd5;
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'h55); step();
    chk("t5_incoming_excl", o_hz, 1'b0);
    drive(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'h0); step();
`ifdef WB_ARB_FWD_EN
    chk("t5_fwd_hit", o_h1, 1'b1);
    chk("t5_fwd_data", o_d1, 32'h55);
    chk("t5_fwd_hz", o_hz, 1'b0);
`else
    chk("t5_hz_queued", o_hz, 1'b1);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); step();
    chk("t5_drain", o_addr, 5'd5);
    step();
    chk("t5_hz_clear", o_hz, 1'b0);
    bus.rd_addr1 = 5'd0;

    // 6: aux write to $0 is swallowed
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD); step();
    chk("t6_ready", o_rdy, 1'b1);
    chk("t6_we", o_we, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); step();
    chk("t6_after", o_we, 1'b0);

    // Randomized traffic; the producer holds aux_* until accepted.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 99) < 2);
      bus.wb_we    = ($urandom_range(0, 99) < 50);
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      bus.rd_addr1 = 5'($urandom_range(0, 7));
      bus.rd_addr2 = 5'($urandom_range(0, 7));
      if (!bus.aux_valid && $urandom_range(0, 99) < 60) begin
        bus.aux_valid = 1'b1;
        bus.aux_addr  = 5'($urandom_range(0, 7));
        bus.aux_data  = $urandom;
      end
      step();
      if (bus.aux_valid && o_rdy) bus.aux_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
